cistercian_scan_controller: RTL

- Time-multiplexes one four-quadrant Cistercian numeral (0-9999, BCD) onto the shared dual Cistercian decoder.
- Phase 0 drives units and tens; phase 1 drives hundreds and thousands.
- Generates quadrant-pair select strobes, blanking gaps, PWM brightness on BI and frame-aligned lamp test.
- Accepts new values through a valid/ready handshake and commits them only at frame boundaries, so no tearing.

---
 rtl/cistercian_scan_if.sv | 12 +
 rtl/cistercian_scan_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cistercian_scan_if.sv
// Value-loading handshake for the Cistercian scan controller.
//   in_valid : producer offers in_data this cycle
//   in_data  : BCD {thousands, hundreds, tens, units}
//   in_ready : controller shadow register is empty
interface cistercian_scan_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/cistercian_scan_controller.sv
// Time-multiplexes one four-digit BCD value onto a shared dual Cistercian
// decoder: ON0 shows units/tens, ON1 shows hundreds/thousands, with blanking
// gaps between phases, PWM on BI and a frame-aligned one-frame lamp test.
// New values arrive through a shadow register and are committed only on the
// last cycle of a frame, so a frame never mixes two values.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          scan enable (low freezes the scan, blanks BI/sel)
//   brightness      PWM duty 0 (1/16) .. 15 (full)
//   lt_req, err_clr lamp-test request pulse, sticky-error clear
//   host            value handshake (slave side)
//   dig_a, dig_b    decoder digit inputs (A1..D1, A2..D2)
//   lt1_n, lt2_n    lamp test, low = all segments lit
//   bi              display enable
//   sel             quadrant-pair strobe: 01 phase 0, 10 phase 1, 00 blank
//   frame_done      pulse on the last cycle of each frame
//   err             sticky flag: a non-BCD nibble was committed
module cistercian_scan_controller #(
  parameter int DWELL = 1024,
  parameter int BLANK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [3:0]        brightness,
  input  logic              lt_req,
  input  logic              err_clr,
  cistercian_scan_if.slave  host,
  output logic [3:0]        dig_a,
  output logic [3:0]        dig_b,
  output logic              lt1_n,
  output logic              lt2_n,
  output logic              bi,
  output logic [1:0]        sel,
  output logic              frame_done,
  output logic              err
);
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK - 1);

  typedef enum logic [1:0] {ON0, BLK0, ON1, BLK1} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    pwm, pwm_n;
  logic          pending;
  logic [15:0]   shadow, active, active_n, clean;
  logic          bad;
  logic          arm, arm_n, lt_on, lt_on_n;
  logic          at_last, next_last, boundary, commit, accept;

  // Non-BCD nibbles are shown as 0 and flagged.
  always_comb begin
    clean = shadow;
    bad   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (shadow[4*i +: 4] > 4'd9) begin
        clean[4*i +: 4] = 4'd0;
        bad = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pwm_n   = pwm;
    if (enable) begin
      cnt_n = cnt + CW'(1);
      case (state)
        ON0:  if (cnt == DW_LAST) begin state_n = BLK0; cnt_n = '0; end
        BLK0: if (cnt == BL_LAST) begin state_n = ON1;  cnt_n = '0; end
        ON1:  if (cnt == DW_LAST) begin state_n = BLK1; cnt_n = '0; end
        default: if (cnt == BL_LAST) begin state_n = ON0; cnt_n = '0; end
      endcase
      pwm_n = (state_n != state) ? 4'd0 : pwm + 4'd1;
    end
  end

  assign at_last   = (state == BLK1) && (cnt == BL_LAST);
  assign next_last = (state_n == BLK1) && (cnt_n == BL_LAST);
  assign boundary  = enable & at_last;
  // Commit uses the registered pending: a value accepted on the boundary
  // cycle waits for the following frame.
  assign commit    = boundary & pending;
  assign accept    = host.in_valid & ~pending;
  assign active_n  = commit ? clean : active;

  // Arm stays set for the whole test so further requests are ignored.
  always_comb begin
    lt_on_n = lt_on;
    arm_n   = arm;
    if (boundary && lt_on) begin
      lt_on_n = 1'b0;
      arm_n   = 1'b0;
    end else begin
      if (boundary && arm) lt_on_n = 1'b1;
      if (lt_req)          arm_n   = 1'b1;
    end
  end

  assign host.in_ready = ~pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ON0;
      cnt        <= '0;
      pwm        <= 4'd0;
      pending    <= 1'b0;
      shadow     <= 16'h0;
      active     <= 16'h0;
      arm        <= 1'b0;
      lt_on      <= 1'b0;
      err        <= 1'b0;
      dig_a      <= 4'd0;
      dig_b      <= 4'd0;
      lt1_n      <= 1'b1;
      lt2_n      <= 1'b1;
      bi         <= 1'b0;
      sel        <= 2'b00;
      frame_done <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pwm    <= pwm_n;
      active <= active_n;
      arm    <= arm_n;
      lt_on  <= lt_on_n;
      lt1_n  <= ~lt_on_n;
      lt2_n  <= ~lt_on_n;

      if (accept) begin
        shadow  <= host.in_data;
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end

      if (commit && bad) err <= 1'b1;
      else if (err_clr)  err <= 1'b0;

      // Decoder-facing outputs follow the state being entered.
      if (enable) begin
        frame_done <= next_last;
        case (state_n)
          ON0: begin
            sel   <= 2'b01;
            bi    <= (pwm_n <= brightness);
            dig_a <= active_n[3:0];
            dig_b <= active_n[7:4];
          end
          ON1: begin
            sel   <= 2'b10;
            bi    <= (pwm_n <= brightness);
            dig_a <= active_n[11:8];
            dig_b <= active_n[15:12];
          end
          default: begin
            sel <= 2'b00;
            bi  <= 1'b0;
          end
        endcase
      end else begin
        sel        <= 2'b00;
        bi         <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end
endmodule
